// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each request is answered LATENCY cycles after acceptance; one transaction is in flight at a time.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic [3:0]    cnt;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   rdata_q;
  logic          rerr_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic accept;
  logic enter_resp;
  logic leave_resp;
  logic req_err;

  assign accept     = req_valid && (cur_state == IDLE);
  assign enter_resp = (cur_state == WAIT) && (cnt == 4'd0);
  assign leave_resp = (cur_state == RESP) && resp_ready;

  // Range check uses the full word address so aliasing above DEPTH_WORDS is flagged.
  assign req_err = (req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (req_valid) begin
          nxt_state = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          nxt_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    if (cur_state == IDLE) begin
      req_ready = 1'b1;
    end
    if (cur_state == RESP) begin
      resp_valid = 1'b1;
    end
  end

  assign state      = cur_state;
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        we_q    <= req_we;
        err_q   <= req_err;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end else if ((cur_state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (enter_resp) begin
        rerr_q  <= err_q;
        rdata_q <= (!err_q && !we_q) ? mem[idx_q] : 32'd0;
      end else if (leave_resp || (cur_state == BAD)) begin
        rerr_q  <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Storage has no reset; a write commits only on the edge entering RESP, so a reset in WAIT drops it.
  always_ff @(posedge clk) begin
    if (enter_resp && !reset && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a word-array reference model produces expected responses,
// a negedge monitor checks data, error, latency, hold stability and idle behaviour.
module tb_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  state;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [DEPTH];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          rr_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode == 0) resp_ready = 1'b1;
      else if (rr_mode == 2) resp_ready = 1'b0;
      else resp_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: word array with byte-lane merge; errors leave it untouched.
  function automatic exp_t model_apply(logic we, logic [31:0] addr, logic [31:0] wd, logic [3:0] ws);
    exp_t e;
    int idx;
    e.rdata = 32'd0;
    e.err   = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
    e.acc   = 0;
    if (!e.err) begin
      idx = int'(addr[31:2]);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        e.rdata = model[idx];
      end
    end
    return e;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input bit hold, input bit drop);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_accept_timeout: got req_ready=%b expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    if (!drop) begin
      e = model_apply(we, addr, wd, ws);
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(sbq.size() == 0 && state == 2'b00 && !resp_valid) && t < 300);
    if (!(sbq.size() == 0 && state == 2'b00 && !resp_valid)) begin
      total++; bad++;
      $display("FAIL idle_timeout: got pending=%0d state=%b expected 0/00", sbq.size(), state);
    end
  endtask

  // Monitor
  bit          busy = 0;
  bit          expect_idle = 0;
  logic [31:0] held_d;
  logic        held_e;
  int          last_first = -1;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy = 0;
      expect_idle = 0;
    end else begin
      if (expect_idle) begin
        chk("idle_after_handshake", 32'(state), 32'd0);
        expect_idle = 0;
      end
      if (resp_valid) begin
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (!busy) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
          end else begin
            e = sbq.pop_front();
            chk("rdata", resp_rdata, e.rdata);
            chk("err", 32'(resp_err), 32'(e.err));
            chk("latency", 32'(cyc - e.acc), 32'(LAT));
            if (last_first >= 0) begin
              total++;
              if (cyc - last_first < LAT + 1) begin
                bad++;
                $display("FAIL resp_gap: got %0d expected >= %0d", cyc - last_first, LAT + 1);
              end
            end
            last_first = cyc;
          end
          busy = 1;
          held_d = resp_rdata;
          held_e = resp_err;
        end else begin
          chk("hold_rdata", resp_rdata, held_d);
          chk("hold_err", 32'(resp_err), 32'(held_e));
        end
        if (resp_ready) begin
          busy = 0;
          expect_idle = 1;
        end
      end else begin
        if (busy) begin
          total++; bad++;
          $display("FAIL resp_dropped: got resp_valid=0 expected 1");
          busy = 0;
        end
        chk("quiet_rdata", resp_rdata, 32'd0);
        chk("quiet_err", 32'(resp_err), 32'd0);
      end
    end
  end

  initial begin
    int t;
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_wstrb = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Known contents everywhere
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, 32'(i * 4), 32'(i) * 32'h01010101 ^ 32'h5A5A0000, 4'hF, 0, 0);
    wait_idle();

    // Full write then readback
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, 0);
    // Partial strobes
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 0);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0);
    do_req(1'b0, 32'h20, 32'd0, 4'h0, 0, 0);
    // wstrb=0 write changes nothing
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 0);
    do_req(1'b0, 32'h20, 32'd0, 4'h0, 0, 0);
    // Errors
    do_req(1'b0, 32'h13, 32'd0, 4'h0, 0, 0);
    do_req(1'b0, 32'(DEPTH * 4), 32'd0, 4'h0, 0, 0);
    do_req(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, 0);
    wait_idle();

    // Stall in RESP with an ignored request on the bus
    rr_mode = 2;
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, 0);
    t = 0;
    while (!resp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reached_resp", 32'(resp_valid), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_resp_valid", 32'(resp_valid), 32'd1);
    end
    req_valid = 1'b0;
    rr_mode = 0;
    wait_idle();
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, 0);
    wait_idle();

    // Reset during WAIT drops the write
    do_req(1'b1, 32'h40, 32'd0, 4'hF, 0, 0);
    wait_idle();
    do_req(1'b1, 32'h40, 32'h12345678, 4'hF, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_err", 32'(resp_err), 32'd0);
    chk("arst_resp_rdata", resp_rdata, 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 32'h40, 32'd0, 4'h0, 0, 0);
    wait_idle();

    // Back-to-back reads with req_valid held high
    for (int i = 0; i < 4; i++)
      do_req(1'b0, 32'(i * 4), 32'd0, 4'h0, 1, 0);
    req_valid = 1'b0;
    wait_idle();

    // Random traffic with random backpressure
    rr_mode = 1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: a = {$urandom_range(0, DEPTH - 1)} * 4 + 32'($urandom_range(1, 3));
        1: a = 32'(DEPTH * 4) + {$urandom_range(0, 1000)} * 4;
        default: a = {$urandom_range(0, DEPTH - 1)} * 4;
      endcase
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0, 0);
    end
    rr_mode = 0;
    wait_idle();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
